correlator_sequencer: RTL and testbench

Integration sequencer for the cross-correlator array. It clears the correlator accumulators, gates the correlator `enable` for an exact number of clock cycles, then freezes the accumulators. It presents the frozen frame to the downstream packetizer/UART through a valid/ready handshake. It sits between the host command decoder (start/stop/length/order) and the correlator's `enable`, `reset` and `order` inputs.

---
 rtl/correlator_sequencer_if.sv | 12 +
 rtl/correlator_sequencer.sv | 136 +++++++++++++
 tb/tb_correlator_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/correlator_sequencer_if.sv
// Frame handshake toward the downstream packetizer: frozen-frame valid/ready
// plus the running count of delivered frames.
interface correlator_sequencer_if #(
    parameter int FRAME_CNT_WIDTH = 16
);
    logic                       frame_valid;
    logic                       frame_ready;
    logic [FRAME_CNT_WIDTH-1:0] frame_count;

    modport master (output frame_valid, output frame_count, input frame_ready);
    modport slave  (input frame_valid, input frame_count, output frame_ready);
endinterface

// File: rtl/correlator_sequencer.sv
// Clears the correlator, enables it for an exact cycle count, freezes it and
// hands the frozen frame downstream over valid/ready.
//   state       | meaning
//   S_IDLE      | waiting for start, all controls low
//   S_CLEAR     | corr_reset held for CLEAR_CYCLES, length/order latched
//   S_INTEGRATE | corr_enable high for len_q cycles
//   S_HOLD      | accumulators frozen, frame_valid high until accepted
module correlator_sequencer #(
    parameter int INT_WIDTH       = 24,
    parameter int CLEAR_CYCLES    = 2,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int STALL_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   continuous,
    input  logic [INT_WIDTH-1:0]   int_len,
    input  logic [7:0]             order_in,
    output logic                   corr_enable,
    output logic                   corr_reset,
    output logic [7:0]             order_out,
    output logic [STALL_WIDTH-1:0] stall_count,
    output logic                   busy,
    correlator_sequencer_if.master frame_if
);
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]       CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [CLR_W-1:0]       CLR_ONE   = CLR_W'(1);
    localparam logic [INT_WIDTH-1:0]   INT_ONE   = INT_WIDTH'(1);
    localparam logic [STALL_WIDTH-1:0] STALL_ONE = STALL_WIDTH'(1);
    localparam logic [FRAME_CNT_WIDTH-1:0] FRM_ONE = FRAME_CNT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_INTEGRATE, S_HOLD} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [CLR_W-1:0]           r_clr_cnt;
    logic [INT_WIDTH-1:0]       r_len_q;
    logic [INT_WIDTH-1:0]       r_int_cnt;
    logic [INT_WIDTH-1:0]       w_len_eff;
    logic                       r_stop_pend;
    logic                       r_corr_enable;
    logic                       r_corr_reset;
    logic                       r_frame_valid;
    logic                       r_busy;
    logic [7:0]                 r_order;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
    logic [STALL_WIDTH-1:0]     r_stall;
    logic                       w_first_clr;
    logic                       w_handshake;

    assign w_first_clr = (r_state == S_CLEAR) && (r_clr_cnt == CLR_LAST);
    // On the first clear cycle len_q is not yet loaded, so use the live input
    // (this keeps CLEAR_CYCLES=1 working).
    assign w_len_eff   = w_first_clr ? ((int_len == '0) ? INT_ONE : int_len) : r_len_q;
    assign w_handshake = r_frame_valid && frame_if.frame_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (start && !stop) w_next = S_CLEAR;
            S_CLEAR:     if (r_clr_cnt == '0) w_next = S_INTEGRATE;
            S_INTEGRATE: begin
                if (stop)                   w_next = S_IDLE;
                else if (r_int_cnt == '0)   w_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_handshake)
                    w_next = (continuous && !r_stop_pend && !stop) ? S_CLEAR : S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt     <= '0;
            r_len_q       <= INT_ONE;
            r_int_cnt     <= '0;
            r_stop_pend   <= 1'b0;
            r_order       <= '0;
            r_frame_count <= '0;
            r_stall       <= '0;
            r_corr_enable <= 1'b0;
            r_corr_reset  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_next == S_CLEAR && r_state != S_CLEAR)
                r_clr_cnt <= CLR_LAST;
            else if (r_state == S_CLEAR && r_clr_cnt != '0)
                r_clr_cnt <= r_clr_cnt - CLR_ONE;

            if (w_first_clr) begin
                r_len_q <= w_len_eff;
                r_order <= order_in;
            end

            if (r_state == S_CLEAR)
                r_int_cnt <= w_len_eff - INT_ONE;
            else if (r_state == S_INTEGRATE && r_int_cnt != '0)
                r_int_cnt <= r_int_cnt - INT_ONE;

            if (r_state == S_CLEAR)
                r_stop_pend <= 1'b0;
            else if (r_state == S_HOLD && stop)
                r_stop_pend <= 1'b1;

            if (r_state == S_HOLD && w_handshake)
                r_frame_count <= r_frame_count + FRM_ONE;

            if (r_state == S_HOLD && !frame_if.frame_ready && r_stall != '1)
                r_stall <= r_stall + STALL_ONE;

            r_corr_reset  <= (w_next == S_CLEAR);
            r_corr_enable <= (w_next == S_INTEGRATE);
            r_frame_valid <= (w_next == S_HOLD);
            r_busy        <= (w_next != S_IDLE);
        end
    end

    assign corr_enable          = r_corr_enable;
    assign corr_reset           = r_corr_reset;
    assign order_out            = r_order;
    assign stall_count          = r_stall;
    assign busy                 = r_busy;
    assign frame_if.frame_valid = r_frame_valid;
    assign frame_if.frame_count = r_frame_count;
endmodule

// File: tb/tb_correlator_sequencer.sv
// Scoreboarded bench for correlator_sequencer: drivers push expected enable
// runs and frames; a negedge monitor pops and compares them.
module tb_correlator_sequencer;
    localparam int INT_WIDTH = 24;
    localparam int CLEAR_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [23:0] int_len = '0;
    logic [7:0]  order_in = '0;
    logic        corr_enable, corr_reset, busy;
    logic [7:0]  order_out;
    logic [15:0] stall_count;

    correlator_sequencer_if #(.FRAME_CNT_WIDTH(16)) fif ();

    correlator_sequencer #(
        .INT_WIDTH(INT_WIDTH), .CLEAR_CYCLES(CLEAR_CYCLES),
        .FRAME_CNT_WIDTH(16), .STALL_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .continuous(continuous), .int_len(int_len), .order_in(order_in),
        .corr_enable(corr_enable), .corr_reset(corr_reset), .order_out(order_out),
        .stall_count(stall_count), .busy(busy), .frame_if(fif.master)
    );

    always #5 clk = ~clk;

    typedef struct { int len; bit ab; } en_t;
    typedef struct { logic [7:0] ord; logic [15:0] cnt; bit rearm; } fr_t;

    en_t enq[$];
    fr_t frq[$];
    int  n_chk = 0;
    int  n_err = 0;
    logic [15:0] m_count = '0;
    int          m_stall = 0;
    logic [7:0]  cur_ord = '0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fv();
        int n = 0;
        while (!fif.frame_valid && n < 500) begin tick(); n++; end
        chk("frame_valid_seen", int'(fif.frame_valid), 1);
    endtask

    task automatic wait_en();
        int n = 0;
        while (!corr_enable && n < 500) begin tick(); n++; end
        chk("corr_enable_seen", int'(corr_enable), 1);
    endtask

    task automatic cmd_start(input int len, input logic [7:0] ord, input bit abort);
        int_len  = len[23:0];
        order_in = ord;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("start_corr_reset", int'(corr_reset), 1);
        chk("start_busy", int'(busy), 1);
        cur_ord = ord;
        if (!abort) enq.push_back('{len: (len == 0) ? 1 : len, ab: 1'b0});
    endtask

    // Serve one HOLD: k stall cycles, optional stop, then accept.
    task automatic serve(input int k, input bit cont, input bit stop_h,
                         input int nlen, input logic [7:0] nord);
        bit rearm;
        rearm = cont && !stop_h;
        wait_fv();
        continuous = cont;
        for (int i = 0; i < k; i++) begin
            if (stop_h && i == 0) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        m_stall += k;
        if (rearm) begin
            int_len  = nlen[23:0];
            order_in = nord;
            enq.push_back('{len: (nlen == 0) ? 1 : nlen, ab: 1'b0});
        end
        m_count = m_count + 16'd1;
        frq.push_back('{ord: cur_ord, cnt: m_count, rearm: rearm});
        if (rearm) cur_ord = nord;
        fif.frame_ready = 1'b1;
        tick();
        fif.frame_ready = 1'b0;
    endtask

    // Monitor
    bit prev_en = 0, prev_rst = 0, hs_pend = 0;
    int en_run = 0, rst_run = 0;
    always @(negedge clk) begin
        en_t e;
        fr_t f;
        if (!reset) begin
            prev_en = 0; prev_rst = 0; hs_pend = 0; en_run = 0; rst_run = 0;
        end else begin
            if (hs_pend) begin
                hs_pend = 0;
                chk("frame_expected", int'(frq.size() > 0), 1);
                if (frq.size() > 0) begin
                    f = frq.pop_front();
                    chk("frame_count", int'(fif.frame_count), int'(f.cnt));
                    chk("valid_after_hs", int'(fif.frame_valid), 0);
                    chk("rearm_corr_reset", int'(corr_reset), int'(f.rearm));
                    chk("busy_after_hs", int'(busy), int'(f.rearm));
                end
            end
            if (fif.frame_valid && fif.frame_ready) begin
                chk("frame_pending", int'(frq.size() > 0), 1);
                if (frq.size() > 0) chk("order_out", int'(order_out), int'(frq[0].ord));
                hs_pend = 1;
            end
            if (corr_enable && corr_reset) chk("en_rst_exclusive", 1, 0);
            if (corr_enable) en_run++;
            else if (prev_en) begin
                chk("en_run_expected", int'(enq.size() > 0), 1);
                if (enq.size() > 0) begin
                    e = enq.pop_front();
                    chk("enable_cycles", en_run, e.len);
                    chk("valid_at_en_fall", int'(fif.frame_valid), e.ab ? 0 : 1);
                    if (e.ab) chk("busy_after_abort", int'(busy), 0);
                end
                en_run = 0;
            end
            if (corr_reset) rst_run++;
            else if (prev_rst) begin
                chk("clear_cycles", rst_run, CLEAR_CYCLES);
                chk("enable_after_clear", int'(corr_enable), 1);
                rst_run = 0;
            end
            prev_en  = corr_enable;
            prev_rst = corr_reset;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int len, k;
        logic [7:0] ord;
        bit pre;
        fif.frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_corr_enable", int'(corr_enable), 0);
        chk("rst_corr_reset", int'(corr_reset), 0);
        chk("rst_order_out", int'(order_out), 0);
        chk("rst_frame_valid", int'(fif.frame_valid), 0);
        chk("rst_frame_count", int'(fif.frame_count), 0);
        chk("rst_stall_count", int'(stall_count), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        tick();

        // Basic frame with ready already high
        fif.frame_ready = 1'b1;
        cmd_start(5, 8'h3C, 0);
        serve(0, 0, 0, 0, 8'h00);
        repeat (2) tick();
        chk("t1_busy", int'(busy), 0);
        chk("t1_frame_count", int'(fif.frame_count), int'(m_count));

        // Zero length behaves as one cycle
        cmd_start(0, 8'h81, 0);
        serve(1, 0, 0, 0, 8'h00);
        tick();

        // Continuous, 4 stall cycles per frame, 3 frames
        cmd_start(3, 8'h11, 0);
        for (int i = 0; i < 3; i++) serve(4, i < 2, 0, 3, 8'(8'h12 + i));
        tick();
        chk("t3_stall_count", int'(stall_count), m_stall);
        chk("t3_frame_count", int'(fif.frame_count), int'(m_count));
        chk("t3_busy", int'(busy), 0);

        // Abort two cycles into integration
        cmd_start(6, 8'h5A, 1);
        wait_en();
        enq.push_back('{len: 2, ab: 1'b1});
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (4) tick();
        chk("abort_frame_count", int'(fif.frame_count), int'(m_count));
        chk("abort_frame_valid", int'(fif.frame_valid), 0);
        chk("abort_busy", int'(busy), 0);

        // Stop while holding in continuous mode
        cmd_start(4, 8'hA5, 0);
        serve(3, 1, 1, 4, 8'h00);
        repeat (6) tick();
        chk("stoph_busy", int'(busy), 0);
        chk("stoph_corr_reset", int'(corr_reset), 0);
        chk("stoph_frame_count", int'(fif.frame_count), int'(m_count));
        continuous = 1'b0;

        // Random single frames; inputs scrambled once integration runs
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(0, 9);
            ord = 8'($urandom_range(0, 255));
            k   = $urandom_range(0, 4);
            pre = (k == 0) && ($urandom_range(0, 1) == 1);
            fif.frame_ready = pre;
            cmd_start(len, ord, 0);
            wait_en();
            int_len  = 24'($urandom);
            order_in = 8'($urandom);
            serve(k, 0, 0, 0, 8'h00);
            tick();
            chk("rand_idle_busy", int'(busy), 0);
        end

        // Random continuous burst
        cmd_start($urandom_range(0, 6), 8'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 4; i++)
            serve($urandom_range(0, 3), i < 3, 0, $urandom_range(0, 6), 8'($urandom_range(0, 255)));
        tick();
        chk("burst_stall_count", int'(stall_count), m_stall);
        chk("burst_frame_count", int'(fif.frame_count), int'(m_count));

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", int'(busy), 0);
        chk("ss_corr_reset", int'(corr_reset), 0);
        repeat (3) tick();
        chk("ss_busy_later", int'(busy), 0);

        // Async reset mid-HOLD
        cmd_start(4, 8'hC3, 0);
        wait_fv();
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_corr_enable", int'(corr_enable), 0);
        chk("arst_corr_reset", int'(corr_reset), 0);
        chk("arst_order_out", int'(order_out), 0);
        chk("arst_frame_valid", int'(fif.frame_valid), 0);
        chk("arst_frame_count", int'(fif.frame_count), 0);
        chk("arst_stall_count", int'(stall_count), 0);
        chk("arst_busy", int'(busy), 0);
        m_count = '0;
        m_stall = 0;
        #10 reset = 1'b1;
        tick();
        chk("post_rst_busy", int'(busy), 0);
        cmd_start(2, 8'h42, 0);
        serve(1, 0, 0, 0, 8'h00);
        repeat (2) tick();
        chk("recover_frame_count", int'(fif.frame_count), int'(m_count));
        chk("recover_stall_count", int'(stall_count), m_stall);

        repeat (3) tick();
        chk("enq_drained", enq.size(), 0);
        chk("frq_drained", frq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
